// File: rtl/signed_result_decoder.sv
// Bit-serial two's-complement to sign/magnitude decoder with valid/ready handshakes.
// Optional BCD split of the magnitude is enabled by defining SIGNED_DECODER_BCD_EN.
module signed_result_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [5:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sign,
    output logic [5:0] out_mag
`ifdef SIGNED_DECODER_BCD_EN
    ,
    output logic [1:0] out_tens,
    output logic [3:0] out_ones
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
`ifdef SIGNED_DECODER_BCD_EN
        ,
        BCD  = 2'd3
`endif
    } state_t;

    state_t     state_q;
    logic [5:0] data_q;
    logic [2:0] cnt_q;
    logic       sign_q;
    logic       seen1_q;
    logic [5:0] mag_q;
    logic       valid_q;
    logic       ready_q;
`ifdef SIGNED_DECODER_BCD_EN
    logic [1:0] tens_q;
    logic [5:0] rem_q;
`endif

    logic       bit_d;
    logic       mag_bit_d;
    logic [5:0] mag_d;

    // Negation: copy bits through the first 1, invert everything after it.
    always_comb begin
        bit_d     = data_q[0];
        mag_bit_d = (sign_q & seen1_q) ? ~bit_d : bit_d;
        mag_d     = {mag_bit_d, mag_q[5:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            seen1_q <= 1'b0;
            mag_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
`ifdef SIGNED_DECODER_BCD_EN
            tens_q  <= '0;
            rem_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        sign_q  <= in_data[5];
                        cnt_q   <= '0;
                        seen1_q <= 1'b0;
                        mag_q   <= '0;
                        ready_q <= 1'b0;
`ifdef SIGNED_DECODER_BCD_EN
                        tens_q  <= '0;
                        rem_q   <= '0;
`endif
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    data_q  <= data_q >> 1;
                    seen1_q <= seen1_q | bit_d;
                    mag_q   <= mag_d;
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q == 3'd5) begin
`ifdef SIGNED_DECODER_BCD_EN
                        rem_q   <= mag_d;
                        state_q <= BCD;
`else
                        valid_q <= 1'b1;
                        state_q <= DONE;
`endif
                    end
                end
`ifdef SIGNED_DECODER_BCD_EN
                BCD: begin
                    if (rem_q >= 6'd10) begin
                        rem_q  <= rem_q - 6'd10;
                        tens_q <= tens_q + 2'd1;
                    end else begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_sign  = sign_q;
    assign out_mag   = mag_q;
`ifdef SIGNED_DECODER_BCD_EN
    assign out_tens  = tens_q;
    assign out_ones  = rem_q[3:0];
`endif

endmodule
